obi_burst_ctrl: RTL and testbench

- Sequencer that drives `counter_plus4` (load and +4 enable) and uses its `cnt_out` as the bus address.
- Turns a host burst command (start address, word count, direction) into single-outstanding OBI word transactions.
- Write data arrives from the host stream over valid/ready; read data returns to the host over valid/ready.
- Sits between the CW305 host-register side and the X-HEEP OBI slave port.

---
 rtl/obi_burst_ctrl.sv | 162 ++++++++++++++++
 tb/tb_obi_burst_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_burst_ctrl.sv
// Burst sequencer: one host command becomes single-outstanding OBI word transfers addressed by an external +4 counter.
// Stalls on wdata_valid_i, obi_gnt_i, obi_rvalid_i and rdata_ready_i; define OBI_BURST_ERR_EN for error-response abort and sticky err_o.
module obi_burst_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      start_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             we_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             wdata_valid_i,
  input  logic [31:0]      wdata_i,
  output logic             wdata_ready_o,
  output logic             rdata_valid_o,
  output logic [31:0]      rdata_o,
  input  logic             rdata_ready_i,
  output logic             cnt_ld_o,
  output logic             cnt_en_o,
  output logic [31:0]      cnt_load_val_o,
  input  logic [31:0]      cnt_addr_i,
`ifdef OBI_BURST_ERR_EN
  input  logic             obi_err_i,
  output logic             err_o,
`endif
  output logic             obi_req_o,
  input  logic             obi_gnt_i,
  output logic [31:0]      obi_addr_o,
  output logic             obi_we_o,
  output logic [3:0]       obi_be_o,
  output logic [31:0]      obi_wdata_o,
  input  logic             obi_rvalid_i,
  input  logic [31:0]      obi_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_REQ,
    S_RESP,
    S_RDOUT,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state, state_d;
  logic [LEN_W-1:0] remaining;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic             resp_err;
  logic             unused_addr_lsb;

`ifdef OBI_BURST_ERR_EN
  assign resp_err = obi_err_i;
`else
  assign resp_err = 1'b0;
`endif

  // Byte offset is dropped: the counter only ever steps whole words.
  assign unused_addr_lsb = ^start_addr_i[1:0];
  assign cnt_load_val_o  = {start_addr_i[31:2], 2'b00};
  assign obi_addr_o      = cnt_addr_i;
  assign obi_we_o        = we_q;
  assign obi_wdata_o     = wdata_q;
  assign obi_be_o        = 4'hF;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0) state_d = S_DONE;
          else if (we_i)   state_d = S_WDATA;
          else             state_d = S_REQ;
        end
      end
      S_WDATA: if (wdata_valid_i) state_d = S_REQ;
      S_REQ:   if (obi_gnt_i)     state_d = S_RESP;
      S_RESP: begin
        if (obi_rvalid_i) begin
          if (resp_err)                state_d = S_DONE;
          else if (!we_q)              state_d = S_RDOUT;
          else if (remaining > LEN_ONE) state_d = S_WDATA;
          else                         state_d = S_DONE;
        end
      end
      S_RDOUT: begin
        if (rdata_ready_i) state_d = (remaining != '0) ? S_REQ : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o        = 1'b1;
    done_o        = 1'b0;
    wdata_ready_o = 1'b0;
    rdata_valid_o = 1'b0;
    obi_req_o     = 1'b0;
    cnt_ld_o      = 1'b0;
    cnt_en_o      = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o   = 1'b0;
        cnt_ld_o = start_i;
      end
      S_WDATA: wdata_ready_o = 1'b1;
      S_REQ: begin
        obi_req_o = 1'b1;
        cnt_en_o  = obi_gnt_i;
      end
      S_RDOUT: rdata_valid_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Request fields come straight from these registers, so they cannot move while REQ waits for grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && (len_i != '0)) begin
            remaining <= len_i;
            we_q      <= we_i;
          end
        end
        S_WDATA: if (wdata_valid_i) wdata_q <= wdata_i;
        S_RESP: begin
          if (obi_rvalid_i) begin
            remaining <= remaining - LEN_ONE;
            if (!we_q && !resp_err) rdata_o <= obi_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OBI_BURST_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                               err_o <= 1'b0;
    else if ((state == S_IDLE) && start_i)                    err_o <= 1'b0;
    else if ((state == S_RESP) && obi_rvalid_i && obi_err_i)  err_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_obi_burst_ctrl.sv
// Bench for obi_burst_ctrl: counter, OBI slave and host are modelled here; expected transfers come from burst arithmetic.
module tb_obi_burst_ctrl;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i;
  logic [31:0]      start_addr_i;
  logic [LEN_W-1:0] len_i;
  logic             we_i;
  logic             busy_o, done_o;
  logic             wdata_valid_i;
  logic [31:0]      wdata_i;
  logic             wdata_ready_o;
  logic             rdata_valid_o;
  logic [31:0]      rdata_o;
  logic             rdata_ready_i;
  logic             cnt_ld_o, cnt_en_o;
  logic [31:0]      cnt_load_val_o, cnt_addr_i;
  logic             obi_req_o, obi_gnt_i;
  logic [31:0]      obi_addr_o;
  logic             obi_we_o;
  logic [3:0]       obi_be_o;
  logic [31:0]      obi_wdata_o;
  logic             obi_rvalid_i;
  logic [31:0]      obi_rdata_i;
`ifdef OBI_BURST_ERR_EN
  logic             obi_err_i, err_o;
`endif

  obi_burst_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_i), .start_addr_i(start_addr_i), .len_i(len_i), .we_i(we_i),
    .busy_o(busy_o), .done_o(done_o),
    .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .rdata_ready_i(rdata_ready_i),
    .cnt_ld_o(cnt_ld_o), .cnt_en_o(cnt_en_o), .cnt_load_val_o(cnt_load_val_o), .cnt_addr_i(cnt_addr_i),
`ifdef OBI_BURST_ERR_EN
    .obi_err_i(obi_err_i), .err_o(err_o),
`endif
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i)
  );

  always #5 clk = ~clk;

  // Word counter that the controller steers (load / +4).
  logic [31:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)        cnt_q <= '0;
    else if (cnt_ld_o) cnt_q <= cnt_load_val_o;
    else if (cnt_en_o) cnt_q <= cnt_q + 32'd4;
  end
  assign cnt_addr_i = cnt_q;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          req_cyc;
  } txn_t;

  txn_t        txq[$];
  logic [31:0] rq[$];
  logic [31:0] wq[$];
  logic [31:0] wd_in[$];
  int          cons_txn[$];
  int checks = 0, errors = 0;
  int done_cnt, ld_cnt, en_cnt, en_err = 0, stab_err = 0, outst_err = 0, hold_err = 0;
  int gnt_delay, resp_delay, err_txn, hold_left, resp_cnt, txn_idx, resp_idx;
  bit resp_pend = 0;
  logic [31:0] resp_addr;

  function automatic logic [31:0] rd_word(input logic [31:0] addr);
    return addr ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a, input int i);
    return (a & 32'hFFFF_FFFC) + 32'(4 * i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observer: everything sampled on the falling edge.
  initial begin : monitor
    int req_run;
    bit p_valid, hold_v;
    logic [31:0] p_addr, p_wd, hold_d;
    logic p_we;
    req_run = 0; p_valid = 0; hold_v = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_run = 0; p_valid = 0; hold_v = 0; resp_pend = 0;
      end else begin
        if (done_o)   done_cnt++;
        if (cnt_ld_o) ld_cnt++;
        if (cnt_en_o) en_cnt++;
        if (cnt_en_o !== (obi_req_o && obi_gnt_i)) en_err++;
        if (obi_req_o) begin
          if (p_valid && (obi_addr_o !== p_addr || obi_we_o !== p_we || obi_wdata_o !== p_wd)) stab_err++;
          req_run++; p_valid = 1; p_addr = obi_addr_o; p_we = obi_we_o; p_wd = obi_wdata_o;
          if (obi_gnt_i) begin
            if (resp_pend) outst_err++;
            txq.push_back('{obi_addr_o, obi_we_o, obi_wdata_o, obi_be_o, req_run});
            resp_pend = 1;
            resp_cnt  = (resp_delay < 0) ? int'($urandom_range(0, 2)) : resp_delay;
            resp_addr = obi_addr_o;
            resp_idx  = txn_idx;
            txn_idx++;
            req_run = 0; p_valid = 0;
          end
        end else begin
          req_run = 0; p_valid = 0;
        end
        if (rdata_valid_o) begin
          if (hold_v && rdata_o !== hold_d) hold_err++;
          if (rdata_ready_i) begin
            rq.push_back(rdata_o); cons_txn.push_back(txq.size()); hold_v = 0;
          end else begin
            hold_v = 1; hold_d = rdata_o;
          end
        end else hold_v = 0;
        if (wdata_valid_i && wdata_ready_o && wq.size() > 0) void'(wq.pop_front());
      end
    end
  end

  // OBI slave and host stream drivers, updated just after the rising edge.
  initial begin : driver
    bit req_act;
    int gcnt;
    req_act = 0; gcnt = 0;
    obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = '0;
    wdata_valid_i = 0; wdata_i = '0; rdata_ready_i = 0;
`ifdef OBI_BURST_ERR_EN
    obi_err_i = 0;
`endif
    forever begin
      @(posedge clk); #1;
      obi_gnt_i = 0; obi_rvalid_i = 0;
`ifdef OBI_BURST_ERR_EN
      obi_err_i = 0;
`endif
      if (resp_pend) begin
        if (resp_cnt == 0) begin
          obi_rvalid_i = 1; obi_rdata_i = rd_word(resp_addr); resp_pend = 0;
`ifdef OBI_BURST_ERR_EN
          obi_err_i = (resp_idx == err_txn);
`endif
        end else resp_cnt--;
      end
      if (obi_req_o) begin
        if (!req_act) begin
          req_act = 1;
          gcnt = (gnt_delay < 0) ? int'($urandom_range(0, 3)) : gnt_delay;
        end
        if (gcnt == 0) begin obi_gnt_i = 1; req_act = 0; end
        else gcnt--;
      end else req_act = 0;
      wdata_valid_i = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
      wdata_i       = (wq.size() > 0) ? wq[0] : 32'h0;
      if (rdata_valid_o && hold_left > 0) begin
        rdata_ready_i = 0; hold_left--;
      end else rdata_ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic burst(input string tag, input logic [31:0] a, input int n, input bit w,
                       input bit poke, input int exp_req_cyc);
    logic [31:0] wexp[$];
    int k, exp_n, exp_rd;
    bit abort;
    txq.delete(); rq.delete(); cons_txn.delete();
    done_cnt = 0; ld_cnt = 0; en_cnt = 0; txn_idx = 0;
    wexp = wd_in; wd_in.delete();
    if (w) foreach (wexp[i]) wq.push_back(wexp[i]);
    @(posedge clk); #1;
    start_i = 1; start_addr_i = a; len_i = LEN_W'(n); we_i = w;
    @(posedge clk); #1;
    start_i = 0;
    if (n == 0) chk($sformatf("%s done_next", tag), 32'(done_o), 32'd1);
    if (poke) begin
      @(posedge clk); #1;
      start_i = 1; start_addr_i = 32'hDEAD_0000; len_i = LEN_W'(5); we_i = !w;
      @(posedge clk); #1;
      start_i = 0;
    end
    k = 0;
    while (busy_o && k < 2000) begin @(posedge clk); #1; k++; end
    chk($sformatf("%s timeout", tag), 32'(k < 2000), 32'd1);
    abort  = (err_txn >= 0) && (err_txn < n);
    exp_n  = abort ? err_txn + 1 : n;
    exp_rd = abort ? err_txn : n;
    chk($sformatf("%s txn_count", tag), 32'(txq.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < txq.size(); i++) begin
      chk($sformatf("%s addr%0d", tag, i), txq[i].addr, exp_addr(a, i));
      chk($sformatf("%s we%0d", tag, i), 32'(txq[i].we), 32'(w));
      chk($sformatf("%s be%0d", tag, i), 32'(txq[i].be), 32'hF);
      if (w) chk($sformatf("%s wdata%0d", tag, i), txq[i].wdata, wexp[i]);
      if (exp_req_cyc > 0) chk($sformatf("%s req_cycles%0d", tag, i), 32'(txq[i].req_cyc), 32'(exp_req_cyc));
    end
    if (!w) begin
      chk($sformatf("%s rd_count", tag), 32'(rq.size()), 32'(exp_rd));
      for (int i = 0; i < exp_rd && i < rq.size(); i++)
        chk($sformatf("%s rdata%0d", tag, i), rq[i], rd_word(exp_addr(a, i)));
    end
    chk($sformatf("%s done_pulses", tag), 32'(done_cnt), 32'd1);
    chk($sformatf("%s ld_pulses", tag), 32'(ld_cnt), 32'd1);
    chk($sformatf("%s en_pulses", tag), 32'(en_cnt), 32'(exp_n));
    chk($sformatf("%s cnt_end", tag), cnt_addr_i, exp_addr(a, exp_n));
    chk($sformatf("%s en_vs_gnt", tag), 32'(en_err), 32'd0);
    chk($sformatf("%s req_stable", tag), 32'(stab_err), 32'd0);
    chk($sformatf("%s outstanding", tag), 32'(outst_err), 32'd0);
    chk($sformatf("%s rdata_hold", tag), 32'(hold_err), 32'd0);
    wq.delete();
  endtask

  initial begin
    logic [31:0] ra;
    int rn;
    bit rw;
    rst_n = 0; start_i = 0; start_addr_i = '0; len_i = '0; we_i = 0;
    gnt_delay = 0; resp_delay = 0; err_txn = -1; hold_left = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst wready", 32'(wdata_ready_o), 32'd0);
    chk("rst rvalid", 32'(rdata_valid_o), 32'd0);
    chk("rst req", 32'(obi_req_o), 32'd0);
    chk("rst ld", 32'(cnt_ld_o), 32'd0);
    chk("rst en", 32'(cnt_en_o), 32'd0);
    chk("rst rdata", rdata_o, 32'h0);
    rst_n = 1;

    wd_in = '{32'hA, 32'hB, 32'hC};
    burst("wr3", 32'h0000_1000, 3, 1, 0, 1);

    resp_delay = 1; hold_left = 3;
    burst("rd2_hold", 32'h0000_2000, 2, 0, 0, 0);
    chk("rd2_hold second_req_after_consume", 32'((cons_txn.size() > 0) ? cons_txn[0] : -1), 32'd1);

    gnt_delay = 4; resp_delay = 0;
    wd_in = '{32'h1111_0001, 32'h2222_0002};
    burst("wr_gnt4", 32'h0000_3004, 2, 1, 0, 5);

    gnt_delay = 0;
    burst("len0", 32'h0000_4000, 0, 1, 0, 0);
    burst("busy_start", 32'h0000_5000, 3, 0, 1, 0);
    burst("wrap", 32'hFFFF_FFF8, 3, 0, 0, 0);

    // Reset while a request is waiting for grant.
    gnt_delay = 10;
    @(posedge clk); #1;
    start_i = 1; start_addr_i = 32'h0000_6000; len_i = LEN_W'(2); we_i = 0;
    @(posedge clk); #1;
    start_i = 0;
    chk("rstreq req_before", 32'(obi_req_o), 32'd1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("rstreq req_after", 32'(obi_req_o), 32'd0);
    chk("rstreq busy_after", 32'(busy_o), 32'd0);
    rst_n = 1;

    gnt_delay = -1; resp_delay = -1;
    for (int t = 0; t < 8; t++) begin
      ra = $urandom; rn = int'($urandom_range(1, 6)); rw = 1'($urandom_range(0, 1));
      if (t == 3) ra = 32'hFFFF_FFF0;
      for (int i = 0; i < rn; i++) wd_in.push_back($urandom);
      burst($sformatf("rnd%0d", t), ra, rn, rw, 0, 0);
    end

`ifdef OBI_BURST_ERR_EN
    err_txn = 1;
    burst("err_rd4", 32'h0000_7000, 4, 0, 0, 0);
    chk("err_rd4 err_o", 32'(err_o), 32'd1);
    err_txn = -1;
    burst("err_clear", 32'h0000_8000, 0, 0, 0, 0);
    chk("err_clear err_o", 32'(err_o), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
